loeffler_dct_8x8: RTL and testbench
===================================

LOEFFLER_DCT_8X8 -- requirements
Module: loeffler_dct_8x8

Interface
REQ-001 The block SHALL have no parameters; sizes are fixed to an 8x8 block, 8-bit samples and 16-bit coefficients.
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 nreset  input  1  reset, asynchronous and active-low.
REQ-004 fetch_addr  output  6  read address into external source memory; index = 8*row + col.
REQ-005 src_data_in  input  8  signed (int8, two's complement) sample, valid one cycle after fetch_addr is presented (synchronous-read memory).
REQ-006 result_write_addr  output  6  write address for output coefficient; index = 8*u + v.
  - u = vertical frequency; v = horizontal frequency.
REQ-007 result_wren  output  1  write strobe for the external output memory, sampled on the rising clock.
REQ-008 result_out  output  16  signed coefficient data, valid while result_wren=1.
REQ-009 finished  output  1  high once all 64 coefficients have been written.

Function
REQ-010 Transform: the block SHALL compute the JPEG forward DCT.
  - F(u,v) = 1/4 C(u) C(v) sum_{x,y} f(y,x) cos((2y+1)u pi/16) cos((2x+1)v pi/16).
  - C(0) = 1/sqrt2; C(k>0) = 1.
  - f(y,x) is the sample at address 8*y + x.
REQ-011 Algorithm: separable; 8 row passes of an 8-point Loeffler 1D DCT (11 multiplies, 29 adds, may be time-multiplexed), then 8 column passes on the intermediate data.
REQ-012 Intermediate storage: internal 64x16-bit scratchpad.
  - Written by the row pass, read by the column pass.
  - Row-pass results SHALL carry at least 3 fractional bits.
REQ-013 Arithmetic: rotation constants quantized to at least 12 fractional bits; all internal sums wide enough that no overflow occurs for any int8 input.
REQ-014 Accuracy: every result_out SHALL be within +/-1 of the double-precision F(u,v) rounded to nearest, for any input block.
REQ-015 Result range: any int8 input gives coefficients within [-1024, +1024], representable in 16 bits two's complement.
REQ-016 Fetch order: row-major.
  - Each of the 64 source addresses SHALL be read at least once per transform.
  - The block SHALL assume no stall from the memory.
REQ-017 Output writes: exactly 64 write strobes per transform, one per address 0..63, each address written once; order is free.
REQ-018 State machine: IDLE/START -> ROW_PASS (8 rows) -> COL_PASS (8 columns, with result writes) -> DONE.
  - DONE is held until reset; exactly one transform per reset release.
REQ-019 finished SHALL rise in the cycle after the last result write and stay high in DONE; result_wren SHALL be 0 in DONE.
REQ-020 Latency: the first fetch SHALL start on the first rising edge after nreset deasserts; finished SHALL be high no later than 900 clock cycles after reset release.
REQ-021 Addresses and data driven while result_wren=0 are don't-care to the consumer but SHALL remain deterministic.

Reset
REQ-022 While nreset=0, outputs SHALL hold these values:
  - fetch_addr = 0; result_write_addr = 0; result_out = 0; result_wren = 0; finished = 0.
  - FSM in IDLE/START; scratchpad contents don't-care.
REQ-023 nreset asserted mid-transform SHALL abort immediately (no further writes).
  - On release, the transform restarts from fetch_addr 0 and produces a correct full result.

Verification
REQ-024 All-zero block -> 64 writes of 0x0000; finished=1 within 900 cycles.
REQ-025 All samples 0x40 (+64) -> address 0 = 0x0200 (512); all other 63 addresses = 0x0000 (+/-1).
REQ-026 All samples 0x80 (-128) -> address 0 = 0xFC00 (-1024); all others 0x0000 (+/-1).
REQ-027 Rows 0-3 = +64, rows 4-7 = -64 -> address 8 (u=1, v=0) = 464 (0x01D0, +/-1).
  - Addresses 0, 16, 32, 48 and every v != 0 = 0 (+/-1).
REQ-028 Reset pulse at cycle 100 of a transform -> wren drops at once, finished stays 0; after release the full 64-coefficient result matches REQ-025 for the all-0x40 block.
REQ-029 Protocol check in every test: exactly 64 result_wren pulses, no duplicate address, no wren before the first fetch data returns, and no wren after finished.

Source files
------------

// File: rtl/loeffler_dct_8x8.sv
// 8x8 forward DCT (JPEG normalisation) built on one shared 8-point Loeffler
// datapath. Eight row transforms of the fetched samples fill a 64x16 scratchpad
// in Q3. Eight column transforms then drain it and emit one coefficient per
// cycle. The block runs exactly one transform per reset release.
//
// Scaling: the unnormalised Loeffler flow-graph output is 2*sqrt(2) times the
// orthonormal 1D DCT. Two passes therefore give 8*F(u,v), and the JPEG scale
// factor reduces to a plain rounding shift at the end of the column pass.
module loeffler_dct_8x8 (
    input  logic        clock,
    input  logic        nreset,
    output logic [5:0]  fetch_addr,
    input  logic [7:0]  src_data_in,
    output logic [5:0]  result_write_addr,
    output logic        result_wren,
    output logic [15:0] result_out,
    output logic        finished
);

    // Rotation constants in Q13; x = cos(x*pi/16).
    localparam logic signed [15:0] K_C3   = 16'sd6811;   // c3
    localparam logic signed [15:0] K_C3A  = -16'sd2260;  // c5 - c3
    localparam logic signed [15:0] K_C3B  = 16'sd11363;  // c3 + c5
    localparam logic signed [15:0] K_C1   = 16'sd8035;   // c1
    localparam logic signed [15:0] K_C1A  = -16'sd6436;  // c7 - c1
    localparam logic signed [15:0] K_C1B  = 16'sd9633;   // c1 + c7
    localparam logic signed [15:0] K_R6   = 16'sd4433;   // sqrt2*c6
    localparam logic signed [15:0] K_R6A  = 16'sd6270;   // sqrt2*(c2 - c6)
    localparam logic signed [15:0] K_R6B  = 16'sd15137;  // sqrt2*(c2 + c6)
    localparam logic signed [15:0] K_SQ2  = 16'sd11585;  // sqrt2

    typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [6:0]             fetch_cnt_q, fetch_cnt_d;
    logic                   rd_vld_q, rd_vld_d;
    logic [5:0]             rd_idx_q, rd_idx_d;
    logic [7:0][7:0]        row_buf_q, row_buf_d;
    logic                   row_go_q, row_go_d;
    logic [2:0]             row_sel_q, row_sel_d;
    logic [7:0][7:0][15:0]  scratch_q, scratch_d;
    logic [2:0]             col_q, col_d;
    logic [2:0]             frq_q, frq_d;
    logic                   wren_q, wren_d;
    logic [5:0]             waddr_q, waddr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   fin_q, fin_d;
    logic                   issue;

    logic signed [31:0]     dp_x [8];
    logic signed [31:0]     dp_y [8];
    logic signed [31:0]     a0, a1, a2, a3, b4, b5, b6, b7;
    logic signed [31:0]     e0, e1, e2, e3, t1, t2, t3;
    logic signed [31:0]     o4, o5, o6, o7, p4, p5, p6, p7;
    logic [7:0][15:0]       row_res;
    logic [7:0][15:0]       col_res;

    // Q13 constant multiply with round-half-up back to the operand scale.
    function automatic logic signed [31:0] mulc(input logic signed [31:0] a,
                                                input logic signed [15:0] k);
        logic signed [47:0] p;
        p = 48'(a) * 48'(k);
        return 32'((p + 48'sd4096) >>> 13);
    endfunction

    // Fetches are issued back-to-back from the first edge after reset until
    // all 64 addresses have been presented.
    assign issue = ((state_q == S_IDLE) || (state_q == S_ROW)) && !fetch_cnt_q[6];

    // Datapath operand select: samples in Q6 during rows, scratch Q3 -> Q7 during columns.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (state_q == S_COL)
                dp_x[i] = {{12{scratch_q[i][col_q][15]}}, scratch_q[i][col_q], 4'b0};
            else
                dp_x[i] = {{18{row_buf_q[i][7]}}, row_buf_q[i], 6'b0};
        end
    end

    // 8-point Loeffler DCT: 11 multiplies, 29 adds, unnormalised output.
    always_comb begin
        a0 = dp_x[0] + dp_x[7];
        a1 = dp_x[1] + dp_x[6];
        a2 = dp_x[2] + dp_x[5];
        a3 = dp_x[3] + dp_x[4];
        b7 = dp_x[0] - dp_x[7];
        b6 = dp_x[1] - dp_x[6];
        b5 = dp_x[2] - dp_x[5];
        b4 = dp_x[3] - dp_x[4];
        // even half
        e0 = a0 + a3;
        e1 = a1 + a2;
        e3 = a0 - a3;
        e2 = a1 - a2;
        t3 = mulc(e2 + e3, K_R6);
        dp_y[0] = e0 + e1;
        dp_y[4] = e0 - e1;
        dp_y[2] = t3 + mulc(e3, K_R6A);
        dp_y[6] = t3 - mulc(e2, K_R6B);
        // odd half: two 3-multiply rotations, butterflies, sqrt2 scaling
        t1 = mulc(b4 + b7, K_C3);
        o4 = t1 + mulc(b7, K_C3A);
        o7 = t1 - mulc(b4, K_C3B);
        t2 = mulc(b5 + b6, K_C1);
        o5 = t2 + mulc(b6, K_C1A);
        o6 = t2 - mulc(b5, K_C1B);
        p7 = o7 + o5;
        p5 = o7 - o5;
        p4 = o4 + o6;
        p6 = o4 - o6;
        dp_y[1] = p7 + p4;
        dp_y[7] = p7 - p4;
        dp_y[3] = mulc(p5, K_SQ2);
        dp_y[5] = mulc(p6, K_SQ2);
    end

    // Rounding: row results Q6 -> Q3; column results 8*F in Q7 -> F.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            row_res[k] = 16'((dp_y[k] + 32'sd4) >>> 3);
            col_res[k] = 16'((dp_y[k] + 32'sd512) >>> 10);
        end
    end

    // Fetch/capture pipeline and scratchpad write for completed rows.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        rd_vld_d    = issue;
        rd_idx_d    = fetch_cnt_q[5:0];
        row_buf_d   = row_buf_q;
        row_go_d    = 1'b0;
        row_sel_d   = row_sel_q;
        scratch_d   = scratch_q;
        if (issue)
            fetch_cnt_d = fetch_cnt_q + 7'd1;
        if (rd_vld_q) begin
            row_buf_d[rd_idx_q[2:0]] = src_data_in;
            if (rd_idx_q[2:0] == 3'd7) begin
                row_go_d  = 1'b1;
                row_sel_d = rd_idx_q[5:3];
            end
        end
        // row_buf holds the full row during the cycle row_go is high
        if (row_go_q)
            scratch_d[row_sel_q] = row_res;
    end

    // Sequencer: row pass -> column pass with one write per cycle -> done.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        frq_d   = frq_q;
        wren_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        fin_d   = fin_q;
        unique case (state_q)
            S_IDLE: state_d = S_ROW;
            S_ROW: begin
                if (row_go_q && (row_sel_q == 3'd7)) begin
                    state_d = S_COL;
                    col_d   = 3'd0;
                    frq_d   = 3'd0;
                end
            end
            S_COL: begin
                wren_d  = 1'b1;
                waddr_d = {frq_q, col_q};
                wdata_d = col_res[frq_q];
                frq_d   = frq_q + 3'd1;
                if (frq_q == 3'd7) begin
                    col_d = col_q + 3'd1;
                    if (col_q == 3'd7)
                        state_d = S_DONE;
                end
            end
            S_DONE: fin_d = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; reset aborts any transform in flight.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            fetch_cnt_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            row_buf_q   <= '0;
            row_go_q    <= 1'b0;
            row_sel_q   <= '0;
            col_q       <= '0;
            frq_q       <= '0;
            wren_q      <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            row_buf_q   <= row_buf_d;
            row_go_q    <= row_go_d;
            row_sel_q   <= row_sel_d;
            col_q       <= col_d;
            frq_q       <= frq_d;
            wren_q      <= wren_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            fin_q       <= fin_d;
        end
    end

    // Scratchpad: fully rewritten by every row pass before it is read.
    always_ff @(posedge clock) begin
        scratch_q <= scratch_d;
    end

    assign fetch_addr        = fetch_cnt_q[5:0];
    assign result_write_addr = waddr_q;
    assign result_wren       = wren_q;
    assign result_out        = wdata_q;
    assign finished          = fin_q;

endmodule

// File: tb/tb_loeffler_dct_8x8.sv
// Directed bench for loeffler_dct_8x8: source memory model, write monitor
// and hand-computed coefficient tables.
module tb_loeffler_dct_8x8;

    logic        clock = 1'b0;
    logic        nreset = 1'b1;
    logic [5:0]  fetch_addr;
    logic [7:0]  src_data_in = '0;
    logic [5:0]  result_write_addr;
    logic        result_wren;
    logic [15:0] result_out;
    logic        finished;

    loeffler_dct_8x8 dut (
        .clock             (clock),
        .nreset            (nreset),
        .fetch_addr        (fetch_addr),
        .src_data_in       (src_data_in),
        .result_write_addr (result_write_addr),
        .result_wren       (result_wren),
        .result_out        (result_out),
        .finished          (finished)
    );

    always #5 clock = ~clock;

    logic [7:0] src_mem [64];
    int         exp_v [64];
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc, wr_cnt, dup_cnt, late_cnt, early_cnt;
    bit         fin_seen;
    bit         written [64];
    int         got [64];

    // synchronous-read source memory
    always @(posedge clock) src_data_in <= src_mem[fetch_addr];

    // write monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (nreset) begin
            cyc++;
            if (result_wren) begin
                wr_cnt++;
                if (cyc < 2) early_cnt++;
                if (fin_seen || finished) late_cnt++;
                if (written[result_write_addr]) dup_cnt++;
                written[result_write_addr] = 1'b1;
                got[result_write_addr] = int'($signed(result_out));
            end
            if (finished) fin_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        n_chk++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_err++;
            $display("FAIL %s got %0d want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic start_run(input string name);
        nreset = 1'b0;
        cyc = 0; wr_cnt = 0; dup_cnt = 0; late_cnt = 0; early_cnt = 0;
        fin_seen = 1'b0;
        for (int a = 0; a < 64; a++) begin
            written[a] = 1'b0;
            got[a] = -99999;
        end
        repeat (3) @(negedge clock);
        chk({name, "_rst_fetch"}, int'(fetch_addr), 0, 0);
        chk({name, "_rst_waddr"}, int'(result_write_addr), 0, 0);
        chk({name, "_rst_data"}, int'(result_out), 0, 0);
        chk({name, "_rst_wren"}, int'(result_wren), 0, 0);
        chk({name, "_rst_fin"}, int'(finished), 0, 0);
        #1 nreset = 1'b1;
        @(negedge clock);
        chk({name, "_first_fetch"}, int'(fetch_addr), 1, 0);
    endtask

    task automatic finish_run(input string name);
        int i = 0;
        while (!finished && i < 898) begin
            @(negedge clock);
            i++;
        end
        chk({name, "_fin"}, int'(finished), 1, 0);
        repeat (4) @(negedge clock);
        chk({name, "_done_wren"}, int'(result_wren), 0, 0);
        chk({name, "_done_fin"}, int'(finished), 1, 0);
        chk({name, "_nwrites"}, wr_cnt, 64, 0);
        chk({name, "_dup"}, dup_cnt, 0, 0);
        chk({name, "_late"}, late_cnt, 0, 0);
        chk({name, "_early"}, early_cnt, 0, 0);
        for (int a = 0; a < 64; a++)
            chk($sformatf("%s_a%0d", name, a), got[a], exp_v[a], 1);
    endtask

    task automatic fill_const(input logic [7:0] v, input int dc);
        for (int a = 0; a < 64; a++) begin
            src_mem[a] = v;
            exp_v[a] = 0;
        end
        exp_v[0] = dc;
    endtask

    initial begin
        #2;
        // all zero
        fill_const(8'h00, 0);
        start_run("zero");
        finish_run("zero");

        // all +64
        fill_const(8'h40, 512);
        start_run("p64");
        finish_run("p64");

        // all -128
        fill_const(8'h80, -1024);
        start_run("m128");
        finish_run("m128");

        // rows 0-3 = +64, rows 4-7 = -64: only u odd, v=0 non-zero
        for (int a = 0; a < 64; a++) begin
            src_mem[a] = (a < 32) ? 8'h40 : 8'hC0;
            exp_v[a] = 0;
        end
        exp_v[8] = 464; exp_v[24] = -163; exp_v[40] = 109; exp_v[56] = -92;
        start_run("rows");
        finish_run("rows");

        // cols 0-3 = +64, cols 4-7 = -64: only u=0, v odd non-zero
        for (int a = 0; a < 64; a++) begin
            src_mem[a] = ((a % 8) < 4) ? 8'h40 : 8'hC0;
            exp_v[a] = 0;
        end
        exp_v[1] = 464; exp_v[3] = -163; exp_v[5] = 109; exp_v[7] = -92;
        start_run("cols");
        finish_run("cols");

        // reset pulse in the middle of the write phase, then a clean rerun
        fill_const(8'h40, 512);
        start_run("abort");
        repeat (99) @(negedge clock);
        chk("abort_busy", int'(result_wren), 1, 0);
        nreset = 1'b0;
        #1;
        chk("abort_wren", int'(result_wren), 0, 0);
        chk("abort_fin", int'(finished), 0, 0);
        chk("abort_fetch", int'(fetch_addr), 0, 0);
        repeat (3) @(negedge clock);
        chk("abort_hold_wren", int'(result_wren), 0, 0);
        chk("abort_hold_fin", int'(finished), 0, 0);
        start_run("rerun");
        finish_run("rerun");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
